// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-aware arbiter that shares one FIFO write port among NUM_REQ producers.
// A requester is granted for one burst. While the FIFO is not full, the arbiter forwards that
// requester's words. The burst is released on the last word, when the request drops, or when
// MAX_BURST words have been accepted.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester acknowledged-word counters and a
// sticky write-acknowledge error flag.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ready,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                          stats_clr,
  output logic [NUM_REQ*16-1:0]         acc_cnt,
  output logic                          ack_err
`endif
);

  localparam int unsigned OwnerW = $clog2(NUM_REQ);
  localparam logic [OwnerW-1:0] OwnerRst = OwnerW'(NUM_REQ - 1);
  localparam logic [7:0] MaxBurstC = 8'(MAX_BURST);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [OwnerW-1:0]   owner_q, owner_d;
  logic [7:0]          cnt_q, cnt_d;

  logic                pick_found;
  logic [OwnerW-1:0]   pick_idx;
  logic                in_burst;
  logic                own_req;
  logic                own_last;
  logic                accept;

  assign in_burst = (state_q == StBurst);
  assign own_req  = req[owner_q];
  assign own_last = req_last[owner_q];
  // A word that is offered during a reset cycle is dropped, so the FIFO never sees it.
  assign accept   = in_burst & own_req & ~fifo_full & ~rst;

  // Round-robin pick: the first set request bit found by searching upward from owner+1, with
  // wrap-around.
  always_comb begin
    logic [31:0] cand;
    pick_found = 1'b0;
    pick_idx   = owner_q;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(owner_q) + 32'(i)) % 32'(NUM_REQ);
      if (!pick_found && req[cand[OwnerW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[OwnerW-1:0];
      end
    end
  end

  // Datapath towards the FIFO and the per-requester accept strobes.
  always_comb begin
    fifo_wr_en   = accept;
    ready        = '0;
    ready[owner_q] = accept;
    fifo_data_in = '0;
    if (in_burst) begin
      fifo_data_in = req_data[32'(owner_q) * FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // Next-state logic: arbitrate in IDLE, count accepted words in BURST, release on exit rules.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d          = StBurst;
          owner_d          = pick_idx;
          gnt_d            = '0;
          gnt_d[pick_idx]  = 1'b1;
          cnt_d            = '0;
        end
      end
      StBurst: begin
        if (!own_req) begin
          state_d = StIdle;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (accept) begin
          if (own_last || (cnt_q + 8'd1 == MaxBurstC)) begin
            state_d = StIdle;
            gnt_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        // The FIFO is full: stall. The grant and the counter are both held.
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers. On reset the owner is set to NUM_REQ-1, so requester 0 wins the first
  // arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= OwnerRst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = in_burst;

`ifdef FIFO_ARB_STATS_EN
  logic                  wr_q;
  logic [OwnerW-1:0]     wr_owner_q;
  logic [NUM_REQ*16-1:0] acc_q;
  logic                  ack_err_q;

  // Remember which requester issued last cycle's write, so the acknowledge can be attributed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= 1'b0;
      wr_owner_q <= OwnerRst;
    end else begin
      wr_q       <= accept;
      wr_owner_q <= owner_q;
    end
  end

  // Acknowledged-word counters and the sticky flag for a missing or unexpected acknowledge.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      acc_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      if (fifo_wr_ack && wr_q) begin
        acc_q[32'(wr_owner_q) * 16 +: 16] <= acc_q[32'(wr_owner_q) * 16 +: 16] + 16'd1;
      end
      if (fifo_wr_ack != wr_q) begin
        ack_err_q <= 1'b1;
      end
    end
  end

  assign acc_cnt = acc_q;
  assign ack_err = ack_err_q;
`else
  logic unused_ack;
  assign unused_ack = fifo_wr_ack;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios and random traffic, compared
// each cycle against a burst-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_last, gnt, ready;
  logic [N*W-1:0] req_data;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_wr_en, fifo_full, fifo_wr_ack;

  always #5 clk = ~clk;

`ifdef FIFO_ARB_STATS_EN
  logic           stats_clr = 1'b0;
  logic [N*16-1:0] acc_cnt;
  logic           ack_err;
  logic           ack_pipe = 1'b0;
  logic           withhold = 1'b0;
  // Model of the FIFO: it acknowledges each write one cycle later, unless the ack is withheld.
  always @(posedge clk) ack_pipe <= fifo_wr_en;
  assign fifo_wr_ack = ack_pipe & ~withhold;
`else
  assign fifo_wr_ack = 1'b0;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_last     (req_last),
    .req_data     (req_data),
    .gnt          (gnt),
    .ready        (ready),
    .owner        (owner),
    .busy         (busy),
    .fifo_data_in (fifo_data_in),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_full    (fifo_full),
    .fifo_wr_ack  (fifo_wr_ack)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .acc_cnt      (acc_cnt),
    .ack_err      (ack_err)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: burst-level state and bookkeeping.
  bit m_busy;
  int m_owner;
  int m_cnt;
  int n_words;
  int words_by[N];
  int grant_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = N - 1;
    m_cnt   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  // One clock cycle: drive the inputs, compare the outputs against the model, advance the model.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d,
                      input logic f, input logic rs);
    logic         exp_we;
    logic [N-1:0] exp_oh;
    @(negedge clk);
    rst = rs; req = r; req_last = l; req_data = d; fifo_full = f;
    #1;
    exp_oh          = '0;
    exp_oh[m_owner] = 1'b1;
    exp_we          = m_busy && r[m_owner] && !f && !rs;
    check("busy",  64'(busy),       64'(m_busy));
    check("gnt",   64'(gnt),        m_busy ? 64'(exp_oh) : 64'd0);
    check("owner", 64'(owner),      64'(m_owner));
    check("wr_en", 64'(fifo_wr_en), 64'(exp_we));
    check("ready", 64'(ready),      exp_we ? 64'(exp_oh) : 64'd0);
    if (exp_we) begin
      check("data", 64'(fifo_data_in), 64'(d[m_owner*W +: W]));
      n_words++;
      words_by[m_owner]++;
    end
    if (rs) begin
      model_reset();
    end else if (!m_busy) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_owner + i) % N;
        if (r[c]) begin
          m_busy = 1'b1; m_owner = c; m_cnt = 0;
          grant_log.push_back(c);
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_busy = 1'b0; m_cnt = 0;
    end else if (!f) begin
      m_cnt++;
      if (l[m_owner] || m_cnt == MB) begin
        m_busy = 1'b0; m_cnt = 0;
      end
    end
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int w0;
    int exp_rot[5] = '{0, 1, 2, 3, 0};
    n_words = 0;
    foreach (words_by[i]) words_by[i] = 0;

    // Reset values, then a 3-word packet from requester 0.
    do_reset();
    #1;
    check("rst_gnt",   64'(gnt),          64'd0);
    check("rst_owner", 64'(owner),        64'(N - 1));
    check("rst_busy",  64'(busy),         64'd0);
    check("rst_wr_en", 64'(fifo_wr_en),   64'd0);
    check("rst_ready", 64'(ready),        64'd0);
    check("rst_data",  64'(fifo_data_in), 64'd0);
    w0 = n_words;
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, (m_busy && m_cnt == 2) ? 4'b0001 : 4'b0000, rnd_data(), 1'b0, 1'b0);
    end
    step(4'b0000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    check("pkt_words", 64'(n_words - w0), 64'd3);

    // All requesters held: the grant rotates and each burst moves MAX_BURST words.
    do_reset();
    grant_log.delete();
    w0 = n_words;
    for (int i = 0; i < 25; i++) step(4'b1111, 4'b0000, rnd_data(), 1'b0, 1'b0);
    check("rot_words", 64'(n_words - w0), 64'd20);
    check("rot_count", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
      check("rot_order", 64'(grant_log[i]), 64'(exp_rot[i]));
    end

    // Owner 2 is stalled mid-burst by a full FIFO.
    do_reset();
    step(4'b0100, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b0100, 4'b0000, rnd_data(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0100, 4'b0000, rnd_data(), 1'b1, 1'b0);
    w0 = n_words;
    for (int i = 0; i < 4; i++) step(4'b0100, 4'b0000, rnd_data(), 1'b0, 1'b0);
    check("stall_resume_words", 64'(n_words - w0), 64'd3);

    // Owner 1 drops its request after 2 words; the next grant goes to requester 2.
    do_reset();
    grant_log.delete();
    step(4'b0010, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b0010, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b0010, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b1100, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b1100, 4'b0000, rnd_data(), 1'b0, 1'b0);
    check("drop_next", 64'(grant_log[grant_log.size()-1]), 64'd2);

    // Reset during the second BURST cycle.
    do_reset();
    grant_log.delete();
    step(4'b0100, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b0100, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b0100, 4'b0000, rnd_data(), 1'b0, 1'b1);
    step(4'b1001, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b1001, 4'b0000, rnd_data(), 1'b0, 1'b0);
    check("rst_regrant", 64'(grant_log[grant_log.size()-1]), 64'd0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom()), ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000, rnd_data(),
           $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
    end

`ifdef FIFO_ARB_STATS_EN
    // Acknowledged-word statistics.
    do_reset();
    step(4'b0000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    w0 = words_by[3];
    for (int i = 0; i < 40 && (words_by[3] - w0) < 5; i++) begin
      step(4'b1000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    end
    step(4'b0000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b0000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    #1;
    check("acc_cnt3", 64'(acc_cnt[3*16 +: 16]), 64'(words_by[3] - w0));
    check("acc_cnt3_five", 64'(acc_cnt[3*16 +: 16]), 64'd5);
    check("ack_err_clean", 64'(ack_err), 64'd0);
    withhold = 1'b1;
    step(4'b1000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b1000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b0000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b0000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    #1;
    check("ack_err_set", 64'(ack_err), 64'd1);
    withhold  = 1'b0;
    stats_clr = 1'b1;
    step(4'b0000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    stats_clr = 1'b0;
    step(4'b0000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    #1;
    check("clr_acc", 64'(acc_cnt), 64'd0);
    check("clr_err", 64'(ack_err), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, burst-aware write-port arbiter that shares one synchronous FIFO write port among NUM_REQ producers.
- Sits between the producer agents and the FIFO data_in/wr_en/full/wr_ack signals.
- Grants one owner per burst, forwards that owner's words while the FIFO is not full, and releases on last-word, request drop or burst limit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- FIFO_WIDTH, 16, data word width
- MAX_BURST, 4, max words accepted per grant (1..255)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester word valid
- req_last  in  NUM_REQ  current word is last of packet
- req_data  in  NUM_REQ*FIFO_WIDTH  packed data, requester i at [i*FIFO_WIDTH +: FIFO_WIDTH]
- gnt  out  NUM_REQ  one-hot registered grant
- ready  out  NUM_REQ  word of requester i accepted this cycle
- owner  out  $clog2(NUM_REQ)  index of current/last owner
- busy  out  1  state is BURST
- fifo_data_in  out  FIFO_WIDTH  to FIFO data_in
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_full  in  1  from FIFO full
- fifo_wr_ack  in  1  from FIFO wr_ack, one cycle after write

Behaviour:
- Reset values:
  - gnt=0, busy=0, owner=NUM_REQ-1, so requester 0 has first priority.
  - ready=0, fifo_wr_en=0, fifo_data_in=0, burst counter=0.
  - State is IDLE.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req bit is set, select the first set bit searching from owner+1 upward, with modulo wrap.
  - Register gnt/owner for the selected requester and go to BURST.
  - Arbitration latency is 1 cycle; no data moves in IDLE.
- BURST:
  - fifo_wr_en = req[owner] & ~fifo_full (combinational).
  - fifo_data_in = req_data slice of owner.
  - ready[owner] = fifo_wr_en; all other ready bits are 0.
  - Each accepted word increments the burst counter.
- BURST exit to IDLE at the next edge when any of the following holds:
  - an accepted word has req_last=1;
  - an accepted word brings the counter to MAX_BURST;
  - req[owner]=0 (no word offered).
- On exit: gnt=0, counter=0, owner retained for rotation.
- Minimum gap between bursts is 1 IDLE cycle.
- fifo_full=1 in BURST: stall with fifo_wr_en=0, keep the grant, counter unchanged. Full never causes release; overflow is never requested.
- Requests from non-owners are ignored until the next IDLE arbitration; there is no preemption.
- The word present in the exit cycle is not accepted unless fifo_wr_en was high.
- MAX_BURST=1: every grant moves exactly one word.
- rst during BURST: all outputs return to reset values at that edge; the in-flight word is not written.
- fifo_wr_ack is used only by the optional feature.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds output acc_cnt (NUM_REQ*16): per-requester count of acknowledged words, incremented on fifo_wr_ack for the owner of the write issued the previous cycle.
  - Adds output ack_err (1, sticky): set if fifo_wr_ack is 0 one cycle after fifo_wr_en=1, or fifo_wr_ack is 1 with no write the previous cycle.
  - Adds input stats_clr (1): clears acc_cnt and ack_err synchronously.
  - rst also clears them.
- Undefined: these ports and registers do not exist; fifo_wr_ack is unused.

Test Plan:
- Reset, then req=4'b0001, req_last high on the 3rd word:
  - gnt=0001 one cycle after req;
  - 3 words written on consecutive cycles;
  - gnt=0 the cycle after the last word.
- req=4'b1111 held, req_last=0, MAX_BURST=4:
  - grants rotate 0,1,2,3,0;
  - exactly 4 fifo_wr_en pulses per grant;
  - 1 idle cycle between grants.
- Owner 2 mid-burst and fifo_full forced high for 3 cycles:
  - fifo_wr_en=0 and ready=0 for those cycles, gnt stays 0100;
  - burst resumes with the same word and counter.
- Owner 1 drops req after 2 words:
  - release next cycle;
  - next grant goes to requester 2 if requesting, else 3, 0.
- rst asserted in 2nd BURST cycle:
  - next cycle gnt=0, fifo_wr_en=0, owner=NUM_REQ-1;
  - with req=4'b1001, first grant is requester 0.
- With FIFO_ARB_STATS_EN:
  - 5 acked writes from requester 3 -> acc_cnt[3]=5;
  - withheld wr_ack -> ack_err=1;
  - stats_clr -> both 0.
